uart_tx_arbiter: RTL and testbench

//  Shares one uartTx instance between NUM_REQ byte-stream requesters (e.g. debug console, status reporter, host replies).

---
 rtl/uart_pkg.sv | 11 +
 rtl/rr_priority_select.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART-side types: byte width and the tx arbiter state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arbState_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request bit after lastOwner, wrapping modulo N.
module rr_priority_select #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] lastOwner,
    output logic [N-1:0]     winner
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Walk lastOwner+1 .. lastOwner+N so lastOwner itself is checked last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IDX_W'((32'(lastOwner) + k) % N);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uartTx between NUM_REQ byte-stream requesters.
// A grant is held for a whole packet (reqLast) or until MAX_BURST bytes have moved.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             reqValid,
    input  logic [NUM_REQ*UART_DATA_W-1:0] reqData,
    input  logic [NUM_REQ-1:0]             reqLast,
    output logic [NUM_REQ-1:0]             reqReady,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic [UART_DATA_W-1:0]         txDataIn,
    output logic                           txWrite,
    input  logic                           txFull
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arbState_t               state;
    logic [IDX_W-1:0]        lastOwner;
    logic [IDX_W-1:0]        ownerIdx;
    logic [IDX_W-1:0]        winIdx;
    logic [NUM_REQ-1:0]      winner;
    logic [CNT_W-1:0]        burstCnt;
    logic [UART_DATA_W-1:0]  selData;
    logic                    selLast;
    logic                    releaseNow;

    rr_priority_select #(
        .N (NUM_REQ)
    ) u_rrSelect (
        .req       (reqValid),
        .lastOwner (lastOwner),
        .winner    (winner)
    );

    // Encode the one-hot winner so the owner can be remembered for the next rotation.
    always_comb begin
        winIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                winIdx = IDX_W'(i);
            end
        end
    end

    // Mux the granted requester's byte and last flag.
    always_comb begin
        selData = '0;
        selLast = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                selData = reqData[i*UART_DATA_W +: UART_DATA_W];
                selLast = reqLast[i];
            end
        end
    end

    // Handshake is combinational on txFull so a byte can move the cycle full drops;
    // rst gates it so a reset mid-packet never leaks a write.
    assign reqReady   = (!rst && (state == ARB_GRANT) && !txFull) ? grant : '0;
    assign txWrite    = |(reqValid & reqReady);
    assign txDataIn   = txWrite ? selData : '0;
    assign releaseNow = selLast || ((32'(burstCnt) + 32'd1) == MAX_BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            burstCnt  <= '0;
            ownerIdx  <= '0;
            lastOwner <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|reqValid) begin
                        grant    <= winner;
                        ownerIdx <= winIdx;
                        busy     <= 1'b1;
                        state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (txWrite) begin
                        if (releaseNow) begin
                            lastOwner <= ownerIdx;
                            grant     <= '0;
                            busy      <= 1'b0;
                            burstCnt  <= '0;
                            state     <= ARB_IDLE;
                        end else begin
                            burstCnt <= burstCnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic checked
// against a packet-level round-robin model of the expected serial byte stream.
module tb_uart_tx_arbiter;

    localparam int unsigned NR    = 4;
    localparam int unsigned MB    = 4;
    localparam int unsigned DEPTH = 512;
    localparam int          LIMIT = 20000;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   reqValid;
    logic [NR*8-1:0] reqData;
    logic [NR-1:0]   reqLast;
    logic [NR-1:0]   reqReady;
    logic [NR-1:0]   grant;
    logic            busy;
    logic [7:0]      txDataIn;
    logic            txWrite;
    logic            txFull;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (NR),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqLast  (reqLast),
        .reqReady (reqReady),
        .grant    (grant),
        .busy     (busy),
        .txDataIn (txDataIn),
        .txWrite  (txWrite),
        .txFull   (txFull)
    );

    int testCount = 0;
    int failCount = 0;

    logic [7:0] mem     [NR][DEPTH];
    logic       lastMem [NR][DEPTH];
    int         wr [NR];
    int         rd [NR];
    int         modelLast;
    logic [7:0] expD [$];
    int         expO [$];

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst      = 1'b1;
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;
        txFull   = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            wr[i] = 0;
            rd[i] = 0;
        end
        modelLast = NR - 1;
    endtask

    task automatic addPacket(input int r, input int len);
        for (int k = 0; k < len; k++) begin
            mem[r][wr[r]]     = 8'($urandom);
            lastMem[r][wr[r]] = (k == len - 1);
            wr[r]++;
        end
    endtask

    // Packet-level model: rotate over requesters with queued bytes, each turn
    // taking bytes until a last flag or MB bytes.
    task automatic buildExpected();
        int   p [NR];
        int   cur;
        int   cnt;
        int   idx;
        logic lastFlag;
        expD.delete();
        expO.delete();
        for (int i = 0; i < NR; i++) p[i] = rd[i];
        while (1) begin
            cur = -1;
            for (int k = 1; k <= NR; k++) begin
                idx = (modelLast + k) % NR;
                if (cur < 0 && p[idx] < wr[idx]) cur = idx;
            end
            if (cur < 0) break;
            cnt = 0;
            do begin
                expD.push_back(mem[cur][p[cur]]);
                expO.push_back(cur);
                lastFlag = lastMem[cur][p[cur]];
                p[cur]++;
                cnt++;
            end while (!lastFlag && cnt < MB);
            modelLast = cur;
        end
    endtask

    task automatic runTraffic(input int fullPct, input int gapPct);
        int          cyc;
        int          xferIdx;
        int          who;
        bit          done;
        logic [NR-1:0] tr;
        buildExpected();
        xferIdx = 0;
        cyc     = 0;
        done    = 1'b0;
        while (!done && cyc < LIMIT) begin
            for (int i = 0; i < NR; i++) begin
                if (rd[i] < wr[i]) begin
                    reqValid[i]       = !busy || (int'($urandom_range(99)) >= gapPct);
                    reqData[i*8 +: 8] = mem[i][rd[i]];
                    reqLast[i]        = lastMem[i][rd[i]];
                end else begin
                    reqValid[i]       = 1'b0;
                    reqData[i*8 +: 8] = 8'h00;
                    reqLast[i]        = 1'b0;
                end
            end
            txFull = (int'($urandom_range(99)) < fullPct);
            sample();
            tr = reqValid & reqReady;
            if (txFull) checkEq("fullBlocksReady", 32'(reqReady), 32'd0);
            if (txWrite) begin
                who = -1;
                for (int i = 0; i < NR; i++) if (tr[i] && who < 0) who = i;
                if (xferIdx < expD.size()) begin
                    checkEq("streamByte", 32'(txDataIn), 32'(expD[xferIdx]));
                    checkEq("streamOwner", 32'(grant), 32'd1 << expO[xferIdx]);
                    checkEq("xferOnehot", 32'($countones(tr)), 32'd1);
                end else begin
                    checkEq("extraXfer", 32'(xferIdx + 1), 32'(expD.size()));
                end
                xferIdx++;
                if (who >= 0) rd[who]++;
            end else begin
                checkEq("idleDataZero", 32'(txDataIn), 32'd0);
            end
            step();
            cyc++;
            done = 1'b1;
            for (int i = 0; i < NR; i++) if (rd[i] < wr[i]) done = 1'b0;
        end
        reqValid = '0;
        reqLast  = '0;
        txFull   = 1'b0;
        sample();
        checkEq("trafficDone", 32'(done), 32'd1);
        checkEq("endIdle", 32'(busy), 32'd0);
        checkEq("xferCount", 32'(xferIdx), 32'(expD.size()));
        step();
    endtask

    initial begin
        rst      = 1'b1;
        reqValid = '1;
        reqData  = '0;
        reqLast  = '0;
        txFull   = 1'b0;
        step();
        sample();
        checkEq("rstGrant", 32'(grant), 32'd0);
        checkEq("rstBusy", 32'(busy), 32'd0);
        checkEq("rstReady", 32'(reqReady), 32'd0);
        checkEq("rstWrite", 32'(txWrite), 32'd0);

        // Single requester, three-byte packet.
        applyReset();
        reqValid = 4'b0001;
        reqData  = 32'h41;
        reqLast  = '0;
        sample();
        checkEq("t1IdleGrant", 32'(grant), 32'd0);
        step();
        sample();
        checkEq("t1Grant", 32'(grant), 32'd1);
        checkEq("t1Byte0", 32'({txWrite, txDataIn}), 32'h141);
        step();
        reqData = 32'h42;
        sample();
        checkEq("t1Byte1", 32'({txWrite, txDataIn}), 32'h142);
        step();
        reqData = 32'h43;
        reqLast = 4'b0001;
        sample();
        checkEq("t1Byte2", 32'({txWrite, txDataIn}), 32'h143);
        step();
        reqValid = '0;
        reqLast  = '0;
        reqData  = '0;
        sample();
        checkEq("t1Release", 32'(grant), 32'd0);

        // All four requesting, strict rotation.
        applyReset();
        for (int r = 0; r < NR; r++) addPacket(r, 2);
        runTraffic(0, 0);

        // txFull held mid-packet.
        applyReset();
        reqValid = 4'b0001;
        reqData  = 32'h55;
        reqLast  = '0;
        sample();
        step();
        sample();
        checkEq("holdFirst", 32'({txWrite, txDataIn}), 32'h155);
        step();
        reqData = 32'h66;
        reqLast = 4'b0001;
        txFull  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sample();
            checkEq("holdWrite", 32'(txWrite), 32'd0);
            checkEq("holdReady", 32'(reqReady), 32'd0);
            checkEq("holdGrant", 32'(grant), 32'd1);
            step();
        end
        txFull = 1'b0;
        sample();
        checkEq("holdResume", 32'({txWrite, txDataIn}), 32'h166);
        step();
        reqValid = '0;
        reqLast  = '0;
        sample();
        checkEq("holdRelease", 32'(busy), 32'd0);

        // Burst limit with another requester pending; a last on the limit byte.
        applyReset();
        addPacket(1, 10);
        addPacket(2, 2);
        addPacket(3, 4);
        runTraffic(0, 0);

        // Reset in the middle of a packet.
        applyReset();
        reqValid = 4'b0001;
        reqData  = 32'h11;
        reqLast  = 4'b0001;
        sample();
        step();
        sample();
        checkEq("rmFirstPkt", 32'({txWrite, txDataIn}), 32'h111);
        step();
        reqValid = 4'b0100;
        reqData  = 32'h0077_0000;
        reqLast  = '0;
        sample();
        checkEq("rmBubble", 32'(grant), 32'd0);
        step();
        sample();
        checkEq("rmGrant2", 32'({txWrite, txDataIn}), 32'h177);
        step();
        rst     = 1'b1;
        reqData = 32'h0078_0000;
        sample();
        checkEq("rmRstWrite", 32'(txWrite), 32'd0);
        checkEq("rmRstReady", 32'(reqReady), 32'd0);
        step();
        rst      = 1'b0;
        reqValid = 4'b0111;
        sample();
        checkEq("rmAfterGrant", 32'(grant), 32'd0);
        checkEq("rmAfterBusy", 32'(busy), 32'd0);
        step();
        sample();
        checkEq("rmRestart", 32'(grant), 32'd1);
        step();
        reqValid = '0;

        // Random traffic, two requesters, 50 packets.
        applyReset();
        for (int k = 0; k < 50; k++) addPacket(int'($urandom_range(1)), int'($urandom_range(6, 1)));
        runTraffic(30, 20);

        // Random traffic, all requesters, packets longer than the burst limit.
        applyReset();
        for (int k = 0; k < 40; k++) addPacket(int'($urandom_range(NR - 1)), int'($urandom_range(9, 1)));
        runTraffic(25, 15);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
